// File: rtl/riscv_pkg.sv
// Shared RV32M definitions: M-extension ALU_OP codes, muldiv FSM state encoding
// and the special operand/result values used by divide corner cases.
package riscv_pkg;

  localparam logic [4:0] ALU_MUL     = 5'b11000;
  localparam logic [4:0] ALU_MULH    = 5'b11001;
  localparam logic [4:0] ALU_MULHSU  = 5'b11010;
  localparam logic [4:0] ALU_MULHU   = 5'b11011;
  localparam logic [4:0] ALU_DIV     = 5'b11100;
  localparam logic [4:0] ALU_REM     = 5'b11101;
  localparam logic [4:0] ALU_LUI_FWD = 5'b11110;
  localparam logic [4:0] ALU_REMU    = 5'b11111;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [31:0] MIN_INT  = 32'h8000_0000;
  localparam logic [31:0] ALL_ONES = 32'hFFFF_FFFF;

  // 11xxx belongs to the M extension, except the LUI forward code sharing that space.
  function automatic logic is_m_op(input logic [4:0] op);
    return (op[4:3] == 2'b11) && (op != ALU_LUI_FWD);
  endfunction

  function automatic logic is_mul_op(input logic [4:0] op);
    return op[4:2] == 3'b110;
  endfunction

endpackage

// File: rtl/muldiv_iter_core.sv
// Iterative RV32M datapath: 64-bit shift-add multiplier / restoring divider on
// operand magnitudes, with final sign correction. MULDIV_FAST_MUL_EN adds a
// single-cycle multiplier output.
module muldiv_iter_core
  import riscv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            load_i,
  input  logic            step_i,
  input  logic [4:0]      alu_op_i,
  input  logic [XLEN-1:0] op_a_i,
  input  logic [XLEN-1:0] op_b_i,
  output logic [XLEN-1:0] res_o,
  output logic [XLEN-1:0] fast_res_o
);

  logic [4:0]        op_q, op_d;
  logic [2*XLEN-1:0] acc_q, acc_d, acc_step, prod;
  logic [XLEN-1:0]   opnd_q, opnd_d;
  logic              neg_res_q, neg_res_d;
  logic              neg_rem_q, neg_rem_d;

  logic              a_signed, b_signed, a_neg, b_neg, is_mul;
  logic [XLEN-1:0]   mag_a, mag_b, quo, rem;
  logic [XLEN:0]     add_sum, rem_sh, sub_diff;

  always_comb begin
    is_mul   = is_mul_op(alu_op_i);
    a_signed = alu_op_i inside {ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_DIV, ALU_REM};
    b_signed = alu_op_i inside {ALU_MUL, ALU_MULH, ALU_DIV, ALU_REM};
    a_neg    = a_signed & op_a_i[XLEN-1];
    b_neg    = b_signed & op_b_i[XLEN-1];
    mag_a    = a_neg ? -op_a_i : op_a_i;
    mag_b    = b_neg ? -op_b_i : op_b_i;
  end

  // Multiply keeps {product_hi, multiplier} in acc; divide keeps {remainder, quotient}.
  always_comb begin
    add_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    rem_sh   = acc_q[2*XLEN-1:XLEN-1];
    sub_diff = rem_sh - {1'b0, opnd_q};
    if (is_mul_op(op_q)) begin
      acc_step = {add_sum, acc_q[XLEN-1:1]};
    end else if (!sub_diff[XLEN]) begin
      acc_step = {sub_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
    end else begin
      acc_step = {rem_sh[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
    end
  end

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    op_d      = op_q;
    acc_d     = acc_q;
    opnd_d    = opnd_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    if (load_i) begin
      op_d      = alu_op_i;
      acc_d     = {{XLEN{1'b0}}, (is_mul ? mag_b : mag_a)};
      opnd_d    = is_mul ? mag_a : mag_b;
      neg_res_d = a_neg ^ b_neg;
      neg_rem_d = a_neg;
    end else if (step_i) begin
      acc_d = acc_step;
    end
  end

  // Result is taken from the post-step value so the last iteration and the
  // sign correction land on the same edge as DONE entry.
  always_comb begin
    prod = neg_res_q ? -acc_step : acc_step;
    quo  = acc_step[XLEN-1:0];
    rem  = acc_step[2*XLEN-1:XLEN];
    case (op_q)
      ALU_MUL:                        res_o = prod[XLEN-1:0];
      ALU_MULH, ALU_MULHSU, ALU_MULHU: res_o = prod[2*XLEN-1:XLEN];
      ALU_DIV:                        res_o = neg_res_q ? -quo : quo;
      ALU_REM, ALU_REMU:              res_o = neg_rem_q ? -rem : rem;
      default:                        res_o = '0;
    endcase
  end

`ifdef MULDIV_FAST_MUL_EN
  logic [2*XLEN-1:0] fast_a, fast_b, fast_p;

  always_comb begin
    fast_a     = {{XLEN{a_neg}}, op_a_i};
    fast_b     = {{XLEN{b_neg}}, op_b_i};
    fast_p     = fast_a * fast_b;
    fast_res_o = (alu_op_i == ALU_MUL) ? fast_p[XLEN-1:0] : fast_p[2*XLEN-1:XLEN];
  end
`else
  assign fast_res_o = '0;
`endif

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (reset) begin
      op_q      <= '0;
      acc_q     <= '0;
      opnd_q    <= '0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
    end else begin
      op_q      <= op_d;
      acc_q     <= acc_d;
      opnd_q    <= opnd_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
    end
  end

endmodule

// File: rtl/muldiv_ctrl.sv
// Execute-stage sequencer for RV32M ops: FSM, iteration counter, pipeline stall
// and divide special-case detection. MULDIV_FAST_MUL_EN selects single-cycle multiply.
module muldiv_ctrl
  import riscv_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int ITER = 32
) (
  input  logic            CLK,
  input  logic            RESET,
  input  logic            START,
  input  logic [4:0]      ALU_OP,
  input  logic [XLEN-1:0] OPA,
  input  logic [XLEN-1:0] OPB,
  input  logic            FLUSH,
  output logic            STALL,
  output logic            BUSY,
  output logic [XLEN-1:0] RESULT,
  output logic            RESULT_VALID
);

  localparam int CNT_W = $clog2(ITER);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ITER - 1);

`ifdef MULDIV_FAST_MUL_EN
  localparam bit FAST_MUL = 1'b1;
`else
  localparam bit FAST_MUL = 1'b0;
`endif

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             valid_q, valid_d;
  logic [XLEN-1:0]  result_q, result_d;

  logic             m_op, accept, special, short_path;
  logic [XLEN-1:0]  special_res, core_res, fast_res;

  always_comb begin
    special     = 1'b0;
    special_res = '0;
    if (OPB == '0) begin
      if (ALU_OP == ALU_DIV) begin
        special     = 1'b1;
        special_res = ALL_ONES;
      end else if (ALU_OP == ALU_REM || ALU_OP == ALU_REMU) begin
        special     = 1'b1;
        special_res = OPA;
      end
    end else if (OPA == MIN_INT && OPB == ALL_ONES) begin
      if (ALU_OP == ALU_DIV) begin
        special     = 1'b1;
        special_res = MIN_INT;
      end else if (ALU_OP == ALU_REM) begin
        special     = 1'b1;
        special_res = '0;
      end
    end
  end

  assign m_op       = is_m_op(ALU_OP);
  assign accept     = START & m_op & ~FLUSH & (state_q == ST_IDLE);
  assign short_path = special | (FAST_MUL & is_mul_op(ALU_OP));

  muldiv_iter_core #(.XLEN(XLEN)) u_core (
    .clk        (CLK),
    .reset      (RESET),
    .load_i     (accept & ~short_path),
    .step_i     (state_q == ST_RUN),
    .alu_op_i   (ALU_OP),
    .op_a_i     (OPA),
    .op_b_i     (OPB),
    .res_o      (core_res),
    .fast_res_o (fast_res)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    busy_d   = 1'b0;
    valid_d  = 1'b0;
    result_d = result_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (short_path) begin
            state_d  = ST_DONE;
            valid_d  = 1'b1;
            result_d = special ? special_res : fast_res;
          end else begin
            state_d = ST_RUN;
            cnt_d   = '0;
            busy_d  = 1'b1;
          end
        end
      end
      ST_RUN: begin
        if (cnt_q == CNT_LAST) begin
          state_d  = ST_DONE;
          valid_d  = 1'b1;
          result_d = core_res;
        end else begin
          cnt_d  = cnt_q + 1'b1;
          busy_d = 1'b1;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    // An abort discards the in-flight op but keeps the last delivered result.
    if (FLUSH) begin
      state_d  = ST_IDLE;
      cnt_d    = '0;
      busy_d   = 1'b0;
      valid_d  = 1'b0;
      result_d = result_q;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      valid_q  <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
      valid_q  <= valid_d;
      result_q <= result_d;
    end
  end

  assign STALL        = ~RESET & (accept | (state_q == ST_RUN));
  assign BUSY         = busy_q;
  assign RESULT       = result_q;
  assign RESULT_VALID = valid_q;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Self-checking bench for muldiv_ctrl: table of directed RV32M vectors plus
// hand-written flush, reset, non-M and back-to-back sequences.
module tb_muldiv_ctrl;
  import riscv_pkg::*;

`ifdef MULDIV_FAST_MUL_EN
  localparam bit FAST_TB = 1'b1;
`else
  localparam bit FAST_TB = 1'b0;
`endif

  typedef struct {
    logic [4:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    bit          special;
    string       name;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset, start, flush;
  logic [4:0]  alu_op;
  logic [31:0] opa, opb;
  logic        stall, busy, result_valid;
  logic [31:0] result;

  int total = 0;
  int bad   = 0;
  logic [31:0] last_exp;
  vec_t vecs[16];

  muldiv_ctrl #(.XLEN(32), .ITER(32)) dut (
    .CLK          (clk),
    .RESET        (reset),
    .START        (start),
    .ALU_OP       (alu_op),
    .OPA          (opa),
    .OPB          (opb),
    .FLUSH        (flush),
    .STALL        (stall),
    .BUSY         (busy),
    .RESULT       (result),
    .RESULT_VALID (result_valid)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v);
    int lat, busy_cnt, stall_cnt, exp_lat;
    exp_lat = (v.special || (FAST_TB && v.op[4:2] == 3'b110)) ? 1 : 33;
    @(negedge clk);
    start = 1'b1; alu_op = v.op; opa = v.a; opb = v.b;
    #1;
    stall_cnt = int'(stall);
    busy_cnt  = 0;
    lat       = 0;
    while (lat < 40) begin
      @(negedge clk);
      start = 1'b0; opa = ~v.a; opb = 32'h5A5A_5A5A;
      #1;
      lat++;
      if (result_valid) break;
      busy_cnt  += int'(busy);
      stall_cnt += int'(stall);
    end
    check({v.name, " result"},  result, v.exp);
    check({v.name, " latency"}, 32'(lat), 32'(exp_lat));
    check({v.name, " busy"},    32'(busy_cnt), 32'(exp_lat - 1));
    check({v.name, " stall"},   32'(stall_cnt), 32'(exp_lat));
    @(negedge clk);
    #1;
    check({v.name, " valid_drop"}, {31'b0, result_valid}, 32'd0);
    check({v.name, " hold"}, result, v.exp);
    last_exp = v.exp;
  endtask

  initial begin
    int lat;
    bit seen;
    logic [4:0] non_m[3];

    vecs[0]  = '{ALU_MUL,    32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b0, "mul_7x-3"};
    vecs[1]  = '{ALU_MULH,   32'h8000_0000,  32'h8000_0000, 32'h4000_0000, 1'b0, "mulh_min2"};
    vecs[2]  = '{ALU_MULHU,  32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0, "mulhu_max"};
    vecs[3]  = '{ALU_MULHSU, 32'hFFFF_FFFF,  32'd2,         32'hFFFF_FFFF, 1'b0, "mulhsu_-1x2"};
    vecs[4]  = '{ALU_MUL,    32'h0001_0000,  32'h0001_0000, 32'h0000_0000, 1'b0, "mul_lo_wrap"};
    vecs[5]  = '{ALU_MULHU,  32'h0001_0000,  32'h0001_0000, 32'h0000_0001, 1'b0, "mulhu_2p32"};
    vecs[6]  = '{ALU_DIV,    32'hFFFF_FFEC,  32'd3,         32'hFFFF_FFFA, 1'b0, "div_-20/3"};
    vecs[7]  = '{ALU_REM,    32'hFFFF_FFEC,  32'd3,         32'hFFFF_FFFE, 1'b0, "rem_-20/3"};
    vecs[8]  = '{ALU_REMU,   32'd20,         32'd3,         32'd2,         1'b0, "remu_20/3"};
    vecs[9]  = '{ALU_DIV,    32'd100,        32'hFFFF_FFF9, 32'hFFFF_FFF2, 1'b0, "div_100/-7"};
    vecs[10] = '{ALU_REM,    32'd100,        32'hFFFF_FFF9, 32'd2,         1'b0, "rem_100/-7"};
    vecs[11] = '{ALU_REMU,   32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1'b0, "remu_min/max"};
    vecs[12] = '{ALU_DIV,    32'd5,          32'd0,         32'hFFFF_FFFF, 1'b1, "div_by0"};
    vecs[13] = '{ALU_REM,    32'd5,          32'd0,         32'd5,         1'b1, "rem_by0"};
    vecs[14] = '{ALU_DIV,    32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1'b1, "div_ovf"};
    vecs[15] = '{ALU_REM,    32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         1'b1, "rem_ovf"};

    // Reset with a pending M op: STALL must stay low and outputs clear.
    reset = 1'b1; start = 1'b1; flush = 1'b0; alu_op = ALU_DIV; opa = 32'd1; opb = 32'd0;
    @(negedge clk); #1;
    check("reset_stall",  {31'b0, stall}, 32'd0);
    check("reset_busy",   {31'b0, busy}, 32'd0);
    check("reset_valid",  {31'b0, result_valid}, 32'd0);
    check("reset_result", result, 32'd0);
    @(negedge clk);
    start = 1'b0; reset = 1'b0;
    #1;
    check("post_reset_stall", {31'b0, stall}, 32'd0);
    last_exp = 32'd0;

    for (int i = 0; i < 16; i++) run_vec(vecs[i]);

    // Non-M codes never stall or start anything.
    non_m[0] = ALU_LUI_FWD; non_m[1] = 5'b00000; non_m[2] = 5'b10101;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      start = 1'b1; alu_op = non_m[i]; opa = 32'd9; opb = 32'd0;
      #1;
      check("nonm_stall", {31'b0, stall}, 32'd0);
      @(negedge clk);
      start = 1'b0;
      #1;
      check("nonm_busy",   {31'b0, busy}, 32'd0);
      check("nonm_valid",  {31'b0, result_valid}, 32'd0);
      check("nonm_result", result, last_exp);
    end

    // FLUSH in the tenth RUN cycle of a divide.
    @(negedge clk);
    start = 1'b1; alu_op = ALU_DIV; opa = 32'd1000; opb = 32'd7;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      start = 1'b0;
    end
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    #1;
    check("flush_busy",   {31'b0, busy}, 32'd0);
    check("flush_valid",  {31'b0, result_valid}, 32'd0);
    check("flush_result", result, last_exp);
    check("flush_stall",  {31'b0, stall}, 32'd0);
    seen = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk); #1;
      if (result_valid) seen = 1'b1;
    end
    check("flush_no_valid", {31'b0, seen}, 32'd0);

    // FLUSH and START together: nothing starts.
    @(negedge clk);
    start = 1'b1; flush = 1'b1; alu_op = ALU_DIV; opa = 32'd9; opb = 32'd2;
    #1;
    check("flush_start_stall", {31'b0, stall}, 32'd0);
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    #1;
    check("flush_start_busy",  {31'b0, busy}, 32'd0);
    check("flush_start_valid", {31'b0, result_valid}, 32'd0);

    // RESET while RUN discards the operation and zeroes RESULT.
    @(negedge clk);
    start = 1'b1; alu_op = ALU_DIV; opa = 32'd1000; opb = 32'd7;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      start = 1'b0;
    end
    reset = 1'b1;
    #1;
    check("run_reset_stall_forced", {31'b0, stall}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("run_reset_busy",   {31'b0, busy}, 32'd0);
    check("run_reset_valid",  {31'b0, result_valid}, 32'd0);
    check("run_reset_result", result, 32'd0);
    check("run_reset_stall",  {31'b0, stall}, 32'd0);
    seen = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk); #1;
      if (result_valid) seen = 1'b1;
    end
    check("run_reset_no_valid", {31'b0, seen}, 32'd0);

    // Back-to-back: START in DONE is ignored and taken one cycle later in IDLE.
    @(negedge clk);
    start = 1'b1; alu_op = ALU_REMU; opa = 32'd20; opb = 32'd3;
    lat = 0;
    while (lat < 40) begin
      @(negedge clk);
      start = 1'b0;
      #1;
      lat++;
      if (result_valid) break;
    end
    check("b2b_first_result",  result, 32'd2);
    check("b2b_first_latency", 32'(lat), 32'd33);
    start = 1'b1; alu_op = ALU_DIV; opa = 32'd5; opb = 32'd0;
    #1;
    check("b2b_done_stall", {31'b0, stall}, 32'd0);
    @(negedge clk); #1;
    check("b2b_idle_valid", {31'b0, result_valid}, 32'd0);
    check("b2b_idle_stall", {31'b0, stall}, 32'd1);
    check("b2b_idle_busy",  {31'b0, busy}, 32'd0);
    @(negedge clk);
    start = 1'b0;
    #1;
    check("b2b_second_valid",  {31'b0, result_valid}, 32'd1);
    check("b2b_second_result", result, 32'hFFFF_FFFF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
